// File: rtl/mio_bus_bridge.sv
// rtl/mio_bus_bridge.sv - memory/IO bridge between the single-cycle core and RAM/peripherals
// Decodes core accesses to RAM, GPIO, 7-segment and timer registers; stalls the core on RAM reads.
module mio_bus_bridge #(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_req,
  output logic [31:0]       cpu_rdata,
  output logic              MIO_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic [31:0]       seg_out,
  output logic              bus_err
);

  localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     count_q;
  logic [RAM_AW-1:0] addr_q;
  logic [15:0]       led_q;
  logic [31:0]       seg_q;
  logic [31:0]       timer_q;
  logic              bus_err_q;

  logic [3:0] region;
  logic       off_zero, off_one;
  logic       sel_ram, sel_gpio, sel_seg, sel_tmr, sel_unm;
  logic       idle, acc, wr, rd_ram;
  logic       unused_lane_bits;

  assign region   = cpu_addr[31:28];
  assign off_zero = (cpu_addr[27:2] == 26'd0);
  assign off_one  = (cpu_addr[27:2] == 26'd1);
  assign sel_ram  = (region == 4'h0);
  assign sel_gpio = (region == 4'hE) && off_zero;
  assign sel_seg  = (region == 4'hF) && off_zero;
  assign sel_tmr  = (region == 4'hF) && off_one;
  assign sel_unm  = !(sel_ram || sel_gpio || sel_seg || sel_tmr);

  assign idle   = (state_q == S_IDLE);
  assign acc    = idle && cpu_req;
  assign wr     = acc && cpu_we;
  assign rd_ram = acc && !cpu_we && sel_ram;

  // Byte lanes are not supported; the low address bits are don't-care.
  assign unused_lane_bits = ^cpu_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      led_q     <= '0;
      seg_q     <= '0;
      timer_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= acc && sel_unm;
      timer_q   <= (wr && sel_tmr) ? cpu_wdata : timer_q + 32'd1;
      if (wr && sel_gpio) led_q <= cpu_wdata[15:0];
      if (wr && sel_seg)  seg_q <= cpu_wdata;
      case (state_q)
        S_IDLE: begin
          if (rd_ram) begin
            addr_q  <= cpu_addr[RAM_AW+1:2];
            count_q <= CW'(RAM_LAT - 1);
            state_q <= (RAM_LAT == 1) ? S_DONE : S_WAIT;
          end
        end
        // Core inputs are ignored here; a started read always completes.
        S_WAIT: begin
          if (count_q == CW'(1)) state_q <= S_DONE;
          else                   count_q <= count_q - CW'(1);
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_en   = !rst && acc && sel_ram;
  assign ram_we   = !rst && wr && sel_ram;
  assign ram_addr = idle ? cpu_addr[RAM_AW+1:2] : addr_q;
  assign ram_din  = cpu_wdata;
  assign led_out  = led_q;
  assign seg_out  = seg_q;
  assign bus_err  = bus_err_q;

  always_comb begin
    cpu_rdata = '0;
    MIO_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          MIO_ready = !rd_ram;
          if (cpu_req && !cpu_we) begin
            if (sel_gpio)     cpu_rdata = {16'b0, sw_in};
            else if (sel_seg) cpu_rdata = seg_q;
            else if (sel_tmr) cpu_rdata = timer_q;
          end
        end
        // ram_dout is valid exactly in this cycle, RAM_LAT cycles after issue.
        S_DONE: begin
          MIO_ready = 1'b1;
          cpu_rdata = ram_dout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_bridge.sv
// tb/tb_mio_bus_bridge.sv - directed scoreboard bench for mio_bus_bridge
// Instance 0 uses RAM_LAT=1, instance 1 uses RAM_LAT=3; each has its own RAM model.
module tb_mio_bus_bridge;

  logic             clk;
  logic             rst;
  logic [1:0]       req, we;
  logic [1:0][31:0] addr, wdata, rdata, ram_din, ram_dout, seg_out;
  logic [1:0]       ready, ram_en, ram_we, bus_err;
  logic [1:0][9:0]  ram_addr;
  logic [1:0][15:0] led_out;
  logic [15:0]      sw_in;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  mio_bus_bridge #(.RAM_AW(10), .RAM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]), .cpu_we(we[0]),
    .cpu_req(req[0]), .cpu_rdata(rdata[0]), .MIO_ready(ready[0]), .ram_en(ram_en[0]),
    .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_dout(ram_dout[0]),
    .sw_in(sw_in), .led_out(led_out[0]), .seg_out(seg_out[0]), .bus_err(bus_err[0]));

  mio_bus_bridge #(.RAM_AW(10), .RAM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .cpu_addr(addr[1]), .cpu_wdata(wdata[1]), .cpu_we(we[1]),
    .cpu_req(req[1]), .cpu_rdata(rdata[1]), .MIO_ready(ready[1]), .ram_en(ram_en[1]),
    .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_dout(ram_dout[1]),
    .sw_in(sw_in), .led_out(led_out[1]), .seg_out(seg_out[1]), .bus_err(bus_err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];
  logic [31:0] p0, q0, q1, q2;

  always @(posedge clk) begin
    if (ram_en[0] && ram_we[0])  mem0[ram_addr[0]] <= ram_din[0];
    if (ram_en[0] && !ram_we[0]) p0 <= mem0[ram_addr[0]];
    if (ram_en[1] && ram_we[1])  mem1[ram_addr[1]] <= ram_din[1];
    if (ram_en[1] && !ram_we[1]) q0 <= mem1[ram_addr[1]];
    q1 <= q0;
    q2 <= q1;
  end
  assign ram_dout[0] = p0;
  assign ram_dout[1] = q2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int k, input logic r, input logic w, input logic [31:0] ad,
                     input logic [31:0] wd);
    req[k] = r; we[k] = w; addr[k] = ad; wdata[k] = wd;
  endtask

  task automatic do_write(input int k, input logic [31:0] ad, input logic [31:0] wd,
                          input logic exp_ramwe);
    logic [31:0] wa;
    wa = ad;
    drv(k, 1'b1, 1'b1, ad, wd);
    @(negedge clk);
    chk("wr_ready", 32'(ready[k]), 32'd1);
    chk("wr_ram_we", 32'(ram_we[k]), 32'(exp_ramwe));
    if (exp_ramwe) chk("wr_ram_addr", 32'(ram_addr[k]), 32'(wa[11:2]));
    step();
    drv(k, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_read(input int k, input logic [31:0] ad, input logic [31:0] exp,
                         input bit toggle, output int low);
    logic [31:0] wa;
    wa = ad;
    sb.push_back(exp);
    drv(k, 1'b1, 1'b0, ad, 32'd0);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready[k]) begin
        chk("rd_data", rdata[k], sb.pop_front());
        step();
        drv(k, 1'b0, 1'b0, 32'd0, 32'd0);
        return;
      end
      low++;
      chk("rd_ram_addr_hold", 32'(ram_addr[k]), 32'(wa[11:2]));
      chk("rd_ram_en", 32'(ram_en[k]), (low == 1) ? 32'd1 : 32'd0);
      chk("rd_ram_we", 32'(ram_we[k]), 32'd0);
      step();
      if (toggle) drv(k, 1'b1, 1'b1, 32'h0000_0FF0 + 32'(i * 4), 32'hFFFF_FFFF);
    end
    checks++;
    errors++;
    $error("FAIL rd_timeout observed=no_ready expected=ready addr=%h", ad);
    void'(sb.pop_front());
    drv(k, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int low;
    rst = 1'b1;
    sw_in = 16'h0000;
    drv(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv(1, 1'b0, 1'b0, 32'd0, 32'd0);
    step(); step();
    @(negedge clk);
    chk("rst_ready0", 32'(ready[0]), 32'd0);
    chk("rst_ready1", 32'(ready[1]), 32'd0);
    chk("rst_led", 32'(led_out[0]), 32'd0);
    chk("rst_seg", seg_out[0], 32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    chk("rst_bus_err", 32'(bus_err[0]), 32'd0);
    step();
    rst = 1'b0;

    // timer counts from zero right after reset
    do_read(0, 32'hF000_0004, 32'h0000_0000, 1'b0, low);
    do_read(0, 32'hF000_0004, 32'h0000_0001, 1'b0, low);
    do_read(0, 32'hF000_0004, 32'h0000_0002, 1'b0, low);
    @(negedge clk);
    chk("idle_ready", 32'(ready[0]), 32'd1);
    chk("idle_rdata", rdata[0], 32'd0);
    chk("idle_ram_en", 32'(ram_en[0]), 32'd0);
    step();

    // RAM write then read, latency 1
    do_write(0, 32'h0000_0010, 32'h1234_5678, 1'b1);
    do_read(0, 32'h0000_0010, 32'h1234_5678, 1'b0, low);
    chk("lat1_low_cycles", 32'(low), 32'd1);

    // RAM read, latency 3, with core inputs changing during the wait
    do_write(1, 32'h0000_0004, 32'hCAFE_F00D, 1'b1);
    do_read(1, 32'h0000_0004, 32'hCAFE_F00D, 1'b1, low);
    chk("lat3_low_cycles", 32'(low), 32'd3);
    do_read(1, 32'h0000_0FF0, 32'hxxxx_xxxx, 1'b0, low);
    chk("lat3_no_stray_write", 32'(low), 32'd3);

    // GPIO
    sw_in = 16'h00FF;
    do_write(0, 32'hE000_0000, 32'h0000_A5A5, 1'b0);
    chk("led_written", 32'(led_out[0]), 32'h0000_A5A5);
    do_read(0, 32'hE000_0000, 32'h0000_00FF, 1'b0, low);
    chk("gpio_low_cycles", 32'(low), 32'd0);

    // 7-segment
    do_write(0, 32'hF000_0000, 32'hDEAD_BEEF, 1'b0);
    chk("seg_written", seg_out[0], 32'hDEAD_BEEF);
    do_read(0, 32'hF000_0000, 32'hDEAD_BEEF, 1'b0, low);

    // timer write and wrap
    do_write(0, 32'hF000_0004, 32'hFFFF_FFFE, 1'b0);
    do_read(0, 32'hF000_0004, 32'hFFFF_FFFE, 1'b0, low);
    do_read(0, 32'hF000_0004, 32'hFFFF_FFFF, 1'b0, low);
    do_read(0, 32'hF000_0004, 32'h0000_0000, 1'b0, low);

    // unmapped accesses
    do_read(0, 32'h5000_0000, 32'h0000_0000, 1'b0, low);
    chk("unm_rd_low_cycles", 32'(low), 32'd0);
    chk("unm_rd_bus_err", 32'(bus_err[0]), 32'd1);
    step();
    chk("unm_bus_err_clear", 32'(bus_err[0]), 32'd0);
    do_read(0, 32'hF000_0008, 32'h0000_0000, 1'b0, low);
    chk("unm_off_bus_err", 32'(bus_err[0]), 32'd1);
    do_write(0, 32'hE000_0004, 32'h0000_1234, 1'b0);
    chk("unm_wr_bus_err", 32'(bus_err[0]), 32'd1);
    chk("unm_wr_led_kept", 32'(led_out[0]), 32'h0000_A5A5);
    step();
    chk("unm_wr_bus_err_clear", 32'(bus_err[0]), 32'd0);

    // reset in the middle of a latency-3 read
    drv(1, 1'b1, 1'b0, 32'h0000_0004, 32'd0);
    @(negedge clk);
    chk("abort_issue_ready", 32'(ready[1]), 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("abort_rst_ready", 32'(ready[1]), 32'd0);
    chk("abort_rst_led", 32'(led_out[0]), 32'd0);
    step();
    rst = 1'b0;
    drv(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("abort_idle_ready", 32'(ready[1]), 32'd1);
    chk("abort_idle_rdata", rdata[1], 32'd0);
    step();
    do_read(1, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, low);
    chk("abort_then_read_low", 32'(low), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
